// File: rtl/bcd_score_counter.sv
// rtl/bcd_score_counter.sv - packed-BCD score counter with saturate/wrap overflow and high-score tracking
//
// Purpose:
//   Holds a DIGITS-digit packed BCD score that is adjusted once per cycle by a
//   signed delta in -9..+9. The delta is built from an add request and a
//   subtract request, and both may be active in the same cycle. The counter
//   also keeps the highest score seen since reset.
//
// Parameters:
//   DIGITS    number of BCD digits (1..8)
//   SATURATE  1 = clamp at all nines on overflow, 0 = wrap modulo 10^DIGITS
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset (clears score and high)
//   clear     in   synchronous clear of the score only (high is kept)
//   add_en    in   apply add_val this cycle
//   add_val   in   [3:0] amount to add, 10..15 treated as 9
//   sub_en    in   apply sub_val this cycle
//   sub_val   in   [3:0] amount to subtract, 10..15 treated as 9
//   score     out  [4*DIGITS-1:0] current score, digit 0 in [3:0]
//   high      out  [4*DIGITS-1:0] highest score since reset
//   ovf       out  one-cycle pulse, last update went above all nines
//   unf       out  one-cycle pulse, last update went below zero
//   new_high  out  one-cycle pulse, high changed on the last edge
//   at_max    out  level, score is all nines

module bcd_score_counter #(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  add_en,
  input  logic [3:0]            add_val,
  input  logic                  sub_en,
  input  logic [3:0]            sub_val,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high,
  output logic                  ovf,
  output logic                  unf,
  output logic                  new_high,
  output logic                  at_max
);

  localparam int              W         = 4 * DIGITS;
  localparam logic [W-1:0]    ALL_NINES = {DIGITS{4'h9}};

  logic [W-1:0]  r_score;
  logic [W-1:0]  r_high;
  logic          r_ovf;
  logic          r_unf;
  logic          r_new_high;

  // ---------------------------------------------------------------------------
  // Net delta: sign plus magnitude (0..9)
  // ---------------------------------------------------------------------------
  logic [3:0]  w_add_mag;
  logic [3:0]  w_sub_mag;
  logic [4:0]  w_net;
  logic        w_neg;
  logic [3:0]  w_mag;

  assign w_add_mag = !add_en ? 4'd0 : ((add_val > 4'd9) ? 4'd9 : add_val);
  assign w_sub_mag = !sub_en ? 4'd0 : ((sub_val > 4'd9) ? 4'd9 : sub_val);

  // 5-bit two's complement difference; bit 4 is the sign.
  assign w_net = {1'b0, w_add_mag} - {1'b0, w_sub_mag};
  assign w_neg = w_net[4];
  // Magnitude fits in 4 bits, so negating the low nibble is sufficient.
  assign w_mag = w_neg ? (4'd0 - w_net[3:0]) : w_net[3:0];

  // ---------------------------------------------------------------------------
  // Decimal ripple chains. Both are evaluated every cycle and the sign picks
  // one. Digit 0 takes the full magnitude, and every higher digit takes only
  // the carry or borrow from the digit below it.
  // ---------------------------------------------------------------------------
  logic [W-1:0]    w_sum;
  logic [W-1:0]    w_diff;
  logic [DIGITS:1] w_carry;
  logic [DIGITS:1] w_borrow;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_digit;
      logic [3:0] w_add_in;
      logic [3:0] w_sub_in;
      logic [4:0] w_s5;
      logic [4:0] w_d5;

      assign w_digit = r_score[4*gi +: 4];

      if (gi == 0) begin : g_lsd
        assign w_add_in = w_mag;
        assign w_sub_in = w_mag;
      end else begin : g_upper
        assign w_add_in = {3'b000, w_carry[gi]};
        assign w_sub_in = {3'b000, w_borrow[gi]};
      end

      // The sum is at most 9 + 9 = 18. At 10 or more, subtracting 10 is the
      // same as adding 6 modulo 16 on the low nibble.
      assign w_s5            = {1'b0, w_digit} + {1'b0, w_add_in};
      assign w_carry[gi+1]   = (w_s5 >= 5'd10);
      assign w_sum[4*gi +: 4] = w_carry[gi+1] ? (w_s5[3:0] + 4'd6) : w_s5[3:0];

      // A negative difference wraps in 5 bits. Adding 10 to the low nibble
      // restores the decimal digit.
      assign w_d5             = {1'b0, w_digit} - {1'b0, w_sub_in};
      assign w_borrow[gi+1]   = w_d5[4];
      assign w_diff[4*gi +: 4] = w_borrow[gi+1] ? (w_d5[3:0] + 4'd10) : w_d5[3:0];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next score and event flags
  // ---------------------------------------------------------------------------
  logic [W-1:0] w_next_score;
  logic         w_ovf;
  logic         w_unf;
  logic         w_beats_high;

  always_comb begin
    w_next_score = r_score;
    w_ovf        = 1'b0;
    w_unf        = 1'b0;
    if (w_mag != 4'd0) begin
      if (!w_neg) begin
        if (w_carry[DIGITS]) begin
          w_ovf        = 1'b1;
          // In wrap mode the ripple result already equals the sum mod 10^DIGITS.
          w_next_score = SATURATE ? ALL_NINES : w_sum;
        end else begin
          w_next_score = w_sum;
        end
      end else begin
        if (w_borrow[DIGITS]) begin
          w_unf        = 1'b1;
          w_next_score = '0;
        end else begin
          w_next_score = w_diff;
        end
      end
    end
  end

  // Valid packed BCD has the same order as an unsigned binary number, so a
  // plain vector compare gives the decimal comparison.
  assign w_beats_high = (w_next_score > r_high);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_score    <= '0;
      r_high     <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_new_high <= 1'b0;
    end else if (clear) begin
      r_score    <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_new_high <= 1'b0;
    end else begin
      r_score    <= w_next_score;
      r_ovf      <= w_ovf;
      r_unf      <= w_unf;
      r_new_high <= w_beats_high;
      if (w_beats_high) begin
        r_high <= w_next_score;
      end
    end
  end

  assign score    = r_score;
  assign high     = r_high;
  assign ovf      = r_ovf;
  assign unf      = r_unf;
  assign new_high = r_new_high;
  assign at_max   = (r_score == ALL_NINES);

endmodule

// File: tb/tb_bcd_score_counter.sv
// tb/tb_bcd_score_counter.sv - scoreboard bench for bcd_score_counter in saturate and wrap modes

module tb_bcd_score_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        add_en = 1'b0;
  logic [3:0]  add_val = 4'd0;
  logic        sub_en = 1'b0;
  logic [3:0]  sub_val = 4'd0;

  logic [11:0] score_s, high_s, score_w, high_w;
  logic        ovf_s, unf_s, nh_s, am_s;
  logic        ovf_w, unf_w, nh_w, am_w;

  always #5 clk = ~clk;

  bcd_score_counter #(.DIGITS(3), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .clear(clear),
    .add_en(add_en), .add_val(add_val), .sub_en(sub_en), .sub_val(sub_val),
    .score(score_s), .high(high_s), .ovf(ovf_s), .unf(unf_s),
    .new_high(nh_s), .at_max(am_s)
  );

  bcd_score_counter #(.DIGITS(3), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear),
    .add_en(add_en), .add_val(add_val), .sub_en(sub_en), .sub_val(sub_val),
    .score(score_w), .high(high_w), .ovf(ovf_w), .unf(unf_w),
    .new_high(nh_w), .at_max(am_w)
  );

  typedef struct {
    logic [11:0] score;
    logic [11:0] high;
    logic        ovf;
    logic        unf;
    logic        nh;
    logic        am;
  } exp_t;

  exp_t q_s[$];
  exp_t q_w[$];
  exp_t e_s, e_w;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state, plain integers; index 0 = saturate, 1 = wrap.
  int m_score[2];
  int m_high[2];

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // One request per cycle: drive inputs, advance the model, push expectations.
  task automatic step(input bit r, input bit c, input bit ae, input int av,
                      input bit se, input int sv);
    int   d;
    int   t;
    exp_t e;
    @(negedge clk);
    reset   = r;
    clear   = c;
    add_en  = ae;
    add_val = 4'(av);
    sub_en  = se;
    sub_val = 4'(sv);
    d = (ae ? ((av > 9) ? 9 : av) : 0) - (se ? ((sv > 9) ? 9 : sv) : 0);
    for (int k = 0; k < 2; k++) begin
      e.ovf = 1'b0;
      e.unf = 1'b0;
      e.nh  = 1'b0;
      if (r) begin
        m_score[k] = 0;
        m_high[k]  = 0;
      end else if (c) begin
        m_score[k] = 0;
      end else begin
        t = m_score[k] + d;
        if (t > 999) begin
          e.ovf      = 1'b1;
          m_score[k] = (k == 0) ? 999 : t - 1000;
        end else if (t < 0) begin
          e.unf      = 1'b1;
          m_score[k] = 0;
        end else begin
          m_score[k] = t;
        end
        if (m_score[k] > m_high[k]) begin
          m_high[k] = m_score[k];
          e.nh      = 1'b1;
        end
      end
      e.score = to_bcd(m_score[k]);
      e.high  = to_bcd(m_high[k]);
      e.am    = (m_score[k] == 999);
      if (k == 0) q_s.push_back(e);
      else        q_w.push_back(e);
    end
  endtask

  task automatic add_n(input int n, input int v);
    repeat (n) step(0, 0, 1, v, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle; pop one expectation per edge.
  always @(posedge clk) begin
    #1;
    if (q_s.size() > 0) begin
      e_s = q_s.pop_front();
      chk("sat_score", 32'(score_s), 32'(e_s.score));
      chk("sat_high",  32'(high_s),  32'(e_s.high));
      chk("sat_ovf",   32'(ovf_s),   32'(e_s.ovf));
      chk("sat_unf",   32'(unf_s),   32'(e_s.unf));
      chk("sat_new_high", 32'(nh_s), 32'(e_s.nh));
      chk("sat_at_max", 32'(am_s),   32'(e_s.am));
    end
    if (q_w.size() > 0) begin
      e_w = q_w.pop_front();
      chk("wrap_score", 32'(score_w), 32'(e_w.score));
      chk("wrap_high",  32'(high_w),  32'(e_w.high));
      chk("wrap_ovf",   32'(ovf_w),   32'(e_w.ovf));
      chk("wrap_unf",   32'(unf_w),   32'(e_w.unf));
      chk("wrap_new_high", 32'(nh_w), 32'(e_w.nh));
      chk("wrap_at_max", 32'(am_w),   32'(e_w.am));
    end
  end

  initial begin
    m_score[0] = 0; m_score[1] = 0;
    m_high[0]  = 0; m_high[1]  = 0;

    // Reset state, then 098 + 5 -> 103 with new_high.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    add_n(10, 9);
    add_n(1, 8);
    add_n(1, 5);
    step(0, 0, 1, 6, 1, 6);          // zero net delta
    step(0, 0, 0, 9, 0, 9);          // no enable

    // 995 + 9 overflows, then + 1 overflows again in saturate mode.
    step(1, 0, 0, 0, 0, 0);
    add_n(110, 9);
    add_n(1, 5);
    add_n(1, 9);
    add_n(1, 1);
    step(0, 0, 0, 0, 1, 15);
    step(0, 0, 0, 0, 1, 3);

    // 003 - 7 underflows, then +4 and -2 together.
    step(1, 0, 0, 0, 0, 0);
    add_n(1, 3);
    step(0, 0, 0, 0, 1, 7);
    step(0, 0, 1, 4, 1, 2);
    step(0, 0, 1, 1, 1, 9);

    // 250 then clear beats add; then add_val 12 counts as 9.
    step(1, 0, 0, 0, 0, 0);
    add_n(27, 9);
    add_n(1, 7);
    step(0, 1, 1, 9, 0, 0);
    step(0, 0, 1, 12, 0, 0);

    // 500 then reset beats add.
    step(1, 0, 0, 0, 0, 0);
    add_n(55, 9);
    add_n(1, 5);
    step(1, 0, 1, 9, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Randomized run biased upward so both boundaries are visited.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 399) == 0),
           ($urandom_range(0, 9) < 7), int'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 3), int'($urandom_range(0, 15)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q_s.size() + q_w.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_score_counter.md
BCD_SCORE_COUNTER -- requirements
Module: bcd_score_counter

Interface
REQ-001 Parameter DIGITS, default 3: number of BCD digits in the score, legal range 1..8.
REQ-002 Parameter SATURATE, default 1: 1 = clamp at all-nines on overflow; 0 = wrap modulo 10^DIGITS.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 clear  in  1  synchronous clear of the score only; the high score is kept.
REQ-006 add_en  in  1  add add_val to the score this cycle.
REQ-007 add_val  in  4  amount to add, 0..9; values 10..15 are treated as 9.
REQ-008 sub_en  in  1  subtract sub_val from the score this cycle.
REQ-009 sub_val  in  4  amount to subtract, 0..9; values 10..15 are treated as 9.
REQ-010 score  out  4*DIGITS  current score, packed BCD, digit 0 (ones) in bits [3:0].
REQ-011 high  out  4*DIGITS  highest score since reset, packed BCD, same layout as score.
REQ-012 ovf  out  1  one-cycle pulse: the last update exceeded 10^DIGITS-1.
REQ-013 unf  out  1  one-cycle pulse: the last update went below zero.
REQ-014 new_high  out  1  one-cycle pulse: high changed on the last edge.
REQ-015 at_max  out  1  level: score equals all nines.

Function
REQ-016 Effective delta SHALL be (add_en ? clamp9(add_val) : 0) - (sub_en ? clamp9(sub_val) : 0), range -9..+9.
REQ-017 When add_en and sub_en are both high, the net delta SHALL be applied in one update.
REQ-018 Each update SHALL take exactly one cycle: the score register shows the new value on the edge after the request.
REQ-019 Per-digit arithmetic SHALL be decimal with carry and borrow rippling through all DIGITS combinationally within the cycle; no digit SHALL ever hold 10..15.
REQ-020 Overflow with SATURATE=1: the score SHALL become all nines and ovf SHALL pulse.
REQ-021 Overflow with SATURATE=0: the score SHALL become (score+delta) mod 10^DIGITS and ovf SHALL pulse.
REQ-022 Underflow, in either mode: the score SHALL clamp to zero and unf SHALL pulse; no wrap below zero.
REQ-023 A delta of zero, or no enable, SHALL leave the score unchanged with ovf=unf=0.
REQ-024 clear SHALL take priority over add_en and sub_en: the score goes to zero and ovf, unf and new_high SHALL be 0 that cycle.
REQ-025 high SHALL be loaded with the next score on the same edge whenever next score > high; new_high SHALL pulse on that edge.
REQ-026 Wrap under SATURATE=0 SHALL NOT lower high; high SHALL only increase between resets.
REQ-027 at_max SHALL be derived combinationally from the registered score.
REQ-028 ovf, unf and new_high SHALL be registered and last exactly one cycle per event; back-to-back events SHALL give back-to-back pulses.

Reset
REQ-029 While reset is high at an edge: score=0, high=0, ovf=0, unf=0, new_high=0, taking priority over clear, add_en and sub_en.
REQ-030 A reset asserted mid-sequence SHALL discard any request presented in the same cycle; the first update after reset is the request on the first cycle with reset low.

Verification
REQ-031 DIGITS=3, score 098, add 5 -> next cycle score=103, high=103, new_high pulse, ovf=0.
REQ-032 DIGITS=3, SATURATE=1, score 995, add 9 -> score=999, ovf pulse, at_max=1; then add 1 -> score=999, ovf pulse again.
REQ-033 DIGITS=3, SATURATE=0, score 995, add 9 -> score=004, ovf pulse, high stays 995 or greater.
REQ-034 Score 003, sub 7 -> score=000, unf pulse; then add 4 with sub 2 in the same cycle -> score=002.
REQ-035 Score 250, high 250, clear with add 9 in the same cycle -> score=000, high=250, no pulses; then add_val=12 -> score=009.
REQ-036 Score 500, reset and add 9 in the same cycle -> score=000, high=000, all pulses 0.
